// File: rtl/divisor_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Imported by the divider top and its subtractor.
package divisor_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width; never below one bit so tiny widths stay legal.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/divisor_sequencial_subtrator.sv
// (N)-bit subtractor with borrow out; the trial-subtract stage of the divider.
module subtrator
    import divisor_pkg::*;
#(
    parameter int N = WIDTH_DEF + 1
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] diff_o,
    output logic         borrow_o
);

    logic [N:0] full_s;

    assign full_s   = {1'b0, a_i} - {1'b0, b_i};
    assign diff_o   = full_s[N-1:0];
    assign borrow_o = full_s[N];

endmodule

// File: rtl/divisor_sequencial.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one shift-subtract per clock, St/Done/Idle handshake.
module divisor_sequencial
    import divisor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 St,
    input  logic [2*WIDTH-1:0]   Dividendo,
    input  logic [WIDTH-1:0]     Divisor,
    output logic                 Done,
    output logic                 Idle,
    output logic [WIDTH-1:0]     Quociente,
    output logic [WIDTH-1:0]     Resto,
    output logic                 Ovf
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH:0]     hi_s;
    logic [WIDTH:0]     diff_s;
    logic               borrow_s;
    logic               unused_acc_msb_s;

    // The partial remainder never reaches 2^WIDTH, so the ACC top bit is shifted out unused.
    assign hi_s             = acc_q[2*WIDTH-1:WIDTH-1];
    assign unused_acc_msb_s = acc_q[2*WIDTH];

    subtrator #(
        .N(WIDTH + 1)
    ) u_sub (
        .a_i      (hi_s),
        .b_i      ({1'b0, div_q}),
        .diff_o   (diff_s),
        .borrow_o (borrow_s)
    );

    // State, accumulator, divisor, counter and overflow registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic: accept, iterate shift-subtract, report.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (St) begin
                    div_d = Divisor;
                    cnt_d = '0;
                    // A high half >= divisor (or a zero divisor) cannot fit in WIDTH quotient bits.
                    if (Dividendo[2*WIDTH-1:WIDTH] >= Divisor) begin
                        ovf_d   = 1'b1;
                        acc_d   = '0;
                        state_d = DONE;
                    end else begin
                        ovf_d   = 1'b0;
                        acc_d   = {1'b0, Dividendo};
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (!borrow_s) begin
                    acc_d = {diff_s, acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {hi_s, acc_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Idle      = (state_q == IDLE);
    assign Done      = (state_q == DONE);
    assign Quociente = acc_q[WIDTH-1:0];
    assign Resto     = acc_q[2*WIDTH-1:WIDTH];
    assign Ovf       = ovf_q;

endmodule

// File: doc/divisor_sequencial.md
Name: divisor_sequencial

Overview:
Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, giving WIDTH-bit quotient and remainder. It is the inverse datapath of the shift-add multiplier and uses the same St/Done/Idle handshake. One shift-subtract iteration per clock. Sits beside the multiplier as the CPU's DIV execution unit.

Parameters:
WIDTH, 16, operand width; dividend is 2*WIDTH, quotient and remainder are WIDTH each

Ports:
Clk  input  1  single system clock, rising edge
Rst  input  1  asynchronous reset, active-high
St  input  1  start request; sampled only while Idle=1
Dividendo  input  2*WIDTH  dividend; sampled on the accepting edge
Divisor  input  WIDTH  divisor; sampled on the accepting edge, held internally
Done  output  1  high for exactly one cycle when the result is valid
Idle  output  1  high while the unit can accept St
Quociente  output  WIDTH  quotient; ACC[WIDTH-1:0]
Resto  output  WIDTH  remainder; ACC[2*WIDTH-1:WIDTH]
Ovf  output  1  overflow or divide-by-zero flag for the last operation

Behaviour:
- One clock domain (Clk). Rst is asynchronous and active-high.
- Rst effects, immediate: state IDLE, ACC (2*WIDTH+1 bits) = 0, divisor register = 0, counter = 0, Ovf = 0. Outputs: Idle=1, Done=0, Quociente=0, Resto=0. Reset mid-operation aborts the operation with no Done pulse.
- FSM states: IDLE, CALC, DONE. Idle = (state==IDLE). Done = (state==DONE).
- Start edge E0 (IDLE and St=1):
  - ACC = {1'b0, Dividendo}; latch Divisor; counter = 0.
  - If Dividendo[2*WIDTH-1:WIDTH] >= Divisor (this includes Divisor=0): set Ovf=1, clear ACC, go to DONE.
  - Otherwise: set Ovf=0, go to CALC.
- CALC, one edge per iteration:
  - t = ACC << 1.
  - diff = t[2*WIDTH:WIDTH] - {1'b0, divisor}, computed at WIDTH+1 bits.
  - If no borrow: ACC = {diff, t[WIDTH-1:1], 1'b1}. Else: ACC = t.
  - counter++. When counter == WIDTH-1 on this edge, go to DONE (WIDTH iterations total).
- DONE lasts one cycle, then returns to IDLE. Normal latency: Done is high in the cycle after edge E_WIDTH (E16 for WIDTH=16). Overflow latency: Done is high in the cycle after E0.
- Quociente, Resto and Ovf hold their values from DONE until the next accepted St or Rst.
- St is ignored in CALC and DONE; no queueing. St held high continuously restarts at the first IDLE cycle.
- Dividendo and Divisor changing after E0 do not affect the running operation.
- Invariant when Ovf=0: Dividendo == Quociente*Divisor + Resto and Resto < Divisor.

Decomposition:
- Package divisor_pkg: WIDTH default constant; state enum {IDLE, CALC, DONE}; counter width = clog2(WIDTH).
- One natural sub-module, subtrator: (WIDTH+1)-bit subtract with a borrow output. It mirrors the multiplier's adder.
- FSM, counter and ACC stay in the top module.

Test Plan:
1. Dividendo=32'd100, Divisor=16'd7, St pulse -> Done one cycle after E16; Quociente=14, Resto=2, Ovf=0; Idle low for 17 cycles.
2. Dividendo=32'hFFFE0001, Divisor=16'hFFFF -> Quociente=16'hFFFF, Resto=0, Ovf=0.
3. Divisor=0, Dividendo=32'd5 -> Done in the cycle after E0; Ovf=1, Quociente=0, Resto=0. Then 32'd9 / 16'd4 -> Ovf clears, Q=2, R=1.
4. Dividendo=32'h00010000, Divisor=16'h0001 -> overflow path: Ovf=1, 1-cycle latency.
5. Start 1000/3, assert Rst mid-cycle at iteration 8 -> Idle=1 and outputs 0 without a clock edge, no Done. After release, 1000/3 -> Q=333, R=1.
6. St held high, Dividendo changed during CALC -> first result unaffected; second operation starts in the first IDLE cycle. A St pulse during DONE is ignored. Random 500-vector check against the invariant.
